qspi_psram_target: RTL and testbench

Synthesizable QSPI target that answers the SoC's quad-SPI PSRAM initiator as a PSRAM device would: it decodes quad read (0xEB) and quad write (0x38) transactions and services them through a byte-wide memory bus master. It sits on the far side of the chip-select/sclk/sio pins, in FPGA prototypes and emulation harnesses, fronting on-chip block RAM. All pin inputs are oversampled in the single system clock domain.

---
 rtl/qspi_psram_target.sv | 210 +++++++++++++++++++++
 tb/tb_qspi_psram_target.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_psram_target.sv
// QSPI PSRAM target: decodes quad read (0xEB) and quad write (0x38) from oversampled pins
// and services them through a byte-wide memory bus master.
module qspi_psram_target #(
  parameter int DUMMY_CYCLES = 6,
  parameter int ADDR_BITS    = 24
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 ce_n_i,
  input  logic                 sclk_i,
  input  logic [3:0]           sio_i,
  output logic [3:0]           sio_o,
  output logic [3:0]           sio_oe_o,
  output logic                 mem_valid_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [7:0]           mem_wdata_o,
  input  logic [7:0]           mem_rdata_i,
  input  logic                 mem_ready_i,
  output logic                 underrun_o
);
  localparam logic [7:0]           LAST_CMD   = 8'd7;
  localparam logic [7:0]           LAST_NIB   = 8'(ADDR_BITS / 4 - 1);
  localparam logic [7:0]           LAST_DUMMY = 8'(DUMMY_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

  logic [1:0] ceSync_q, sclkSync_q;
  logic [3:0] sioMeta_q, sioSync_q;
  logic       cePrev_q, sclkPrev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ceSync_q   <= 2'b11;
      sclkSync_q <= 2'b00;
      sioMeta_q  <= 4'h0;
      sioSync_q  <= 4'h0;
      cePrev_q   <= 1'b1;
      sclkPrev_q <= 1'b0;
    end else begin
      ceSync_q   <= {ceSync_q[0], ce_n_i};
      sclkSync_q <= {sclkSync_q[0], sclk_i};
      sioMeta_q  <= sio_i;
      sioSync_q  <= sioMeta_q;
      cePrev_q   <= ceSync_q[1];
      sclkPrev_q <= sclkSync_q[1];
    end
  end

  logic ceHigh, ceFall, sclkRise, sclkFall;
  assign ceHigh   = ceSync_q[1];
  assign ceFall   = !ceSync_q[1] && cePrev_q;
  assign sclkRise = sclkSync_q[1] && !sclkPrev_q;
  assign sclkFall = !sclkSync_q[1] && sclkPrev_q;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d, cmd_q, cmd_d;
  logic                   isRead_q, isRead_d, nibPhase_q, nibPhase_d;
  logic [3:0]             nibHi_q, nibHi_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d, memAddr_q, memAddr_d;
  logic [7:0]             curByte_q, curByte_d, holdReg_q, holdReg_d, memWdata_q, memWdata_d;
  logic                   holdValid_q, holdValid_d, rdWant_q, rdWant_d, discard_q, discard_d;
  logic                   memValid_q, memValid_d, memWe_q, memWe_d, underrun_q, underrun_d;
  logic [3:0]             sioO_q, sioO_d, sioOe_q, sioOe_d;
  logic                   rdAck, accept, holdNowValid;
  logic [7:0]             holdNow;

  // A read acknowledged in the same cycle its byte is due still counts as arrived in time.
  always_comb begin
    state_d     = state_q;     cnt_d      = cnt_q;      cmd_d      = cmd_q;
    isRead_d    = isRead_q;    nibPhase_d = nibPhase_q; nibHi_d    = nibHi_q;
    addr_d      = addr_q;      memAddr_d  = memAddr_q;  curByte_d  = curByte_q;
    holdReg_d   = holdReg_q;   memWdata_d = memWdata_q; holdValid_d = holdValid_q;
    rdWant_d    = rdWant_q;    discard_d  = discard_q;  memValid_d = memValid_q;
    memWe_d     = memWe_q;     underrun_d = underrun_q; sioO_d     = sioO_q;
    sioOe_d     = sioOe_q;

    rdAck        = memValid_q && mem_ready_i && !memWe_q;
    accept       = rdAck && !discard_q;
    holdNowValid = holdValid_q || accept;
    holdNow      = accept ? mem_rdata_i : holdReg_q;

    if (memValid_q && mem_ready_i) memValid_d = 1'b0;
    if (rdAck) discard_d = 1'b0;
    if (accept) begin
      holdReg_d   = mem_rdata_i;
      holdValid_d = 1'b1;
    end

    if (ceHigh) begin
      state_d     = IDLE;
      sioOe_d     = 4'h0;
      rdWant_d    = 1'b0;
      holdValid_d = 1'b0;
      if (memValid_q && !mem_ready_i && !memWe_q) discard_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (ceFall) begin
          state_d = CMD;
          cnt_d   = 8'd0;
        end
        CMD: if (sclkRise) begin
          cmd_d = {cmd_q[6:0], sioSync_q[0]};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CMD) begin
            cnt_d    = 8'd0;
            isRead_d = (cmd_d == 8'hEB);
            state_d  = (cmd_d == 8'hEB || cmd_d == 8'h38) ? ADDR : IGNORE;
          end
        end
        ADDR: if (sclkRise) begin
          addr_d = {addr_q[ADDR_BITS-5:0], sioSync_q};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == LAST_NIB) begin
            cnt_d      = 8'd0;
            nibPhase_d = 1'b0;
            if (isRead_q) begin
              state_d  = DUMMY;
              rdWant_d = 1'b1;
            end else begin
              state_d = WDATA;
            end
          end
        end
        DUMMY: if (sclkRise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_DUMMY) begin
            cnt_d      = 8'd0;
            nibPhase_d = 1'b0;
            state_d    = RDATA;
          end
        end
        // On underrun the late read is dropped so the stream realigns on the next address.
        RDATA: if (sclkFall) begin
          sioOe_d = 4'hF;
          if (!nibPhase_q) begin
            curByte_d   = holdNow;
            sioO_d      = holdNow[7:4];
            nibPhase_d  = 1'b1;
            holdValid_d = 1'b0;
            if (!holdNowValid) begin
              underrun_d = 1'b1;
              if (memValid_q && !mem_ready_i && !memWe_q) discard_d = 1'b1;
            end
            addr_d   = addr_q + ADDR_ONE;
            rdWant_d = 1'b1;
          end else begin
            sioO_d     = curByte_q[3:0];
            nibPhase_d = 1'b0;
          end
        end
        WDATA: if (sclkRise) begin
          if (!nibPhase_q) begin
            nibHi_d    = sioSync_q;
            nibPhase_d = 1'b1;
          end else begin
            nibPhase_d = 1'b0;
            if (memValid_q) begin
              underrun_d = 1'b1;
            end else begin
              memValid_d = 1'b1;
              memWe_d    = 1'b1;
              memAddr_d  = addr_q;
              memWdata_d = {nibHi_q, sioSync_q};
            end
            addr_d = addr_q + ADDR_ONE;
          end
        end
        IGNORE: sioOe_d = 4'h0;
        default: state_d = IDLE;
      endcase

      if (rdWant_d && !memValid_q) begin
        memValid_d = 1'b1;
        memWe_d    = 1'b0;
        memAddr_d  = addr_d;
        rdWant_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;  cnt_q      <= 8'd0;  cmd_q      <= 8'd0;
      isRead_q    <= 1'b0;  nibPhase_q <= 1'b0;  nibHi_q    <= 4'h0;
      addr_q      <= '0;    memAddr_q  <= '0;    curByte_q  <= 8'd0;
      holdReg_q   <= 8'd0;  memWdata_q <= 8'd0;  holdValid_q <= 1'b0;
      rdWant_q    <= 1'b0;  discard_q  <= 1'b0;  memValid_q <= 1'b0;
      memWe_q     <= 1'b0;  underrun_q <= 1'b0;  sioO_q     <= 4'h0;
      sioOe_q     <= 4'h0;
    end else begin
      state_q     <= state_d;     cnt_q      <= cnt_d;      cmd_q      <= cmd_d;
      isRead_q    <= isRead_d;    nibPhase_q <= nibPhase_d; nibHi_q    <= nibHi_d;
      addr_q      <= addr_d;      memAddr_q  <= memAddr_d;  curByte_q  <= curByte_d;
      holdReg_q   <= holdReg_d;   memWdata_q <= memWdata_d; holdValid_q <= holdValid_d;
      rdWant_q    <= rdWant_d;    discard_q  <= discard_d;  memValid_q <= memValid_d;
      memWe_q     <= memWe_d;     underrun_q <= underrun_d; sioO_q     <= sioO_d;
      sioOe_q     <= sioOe_d;
    end
  end

  assign sio_o       = sioO_q;
  assign sio_oe_o    = sioOe_q;
  assign mem_valid_o = memValid_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;
  assign underrun_o  = underrun_q;
endmodule

// File: tb/tb_qspi_psram_target.sv
// Directed bench for qspi_psram_target: a task-driven QSPI initiator plus a byte-wide
// memory model with programmable ready latency.
`timescale 1ns/1ps
module tb_qspi_psram_target;
  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_n = 1'b1;
  logic        sclk = 1'b0;
  logic [3:0]  sio_i = 4'h0;
  logic [3:0]  sio_o, sio_oe;
  logic        mem_valid, mem_we, mem_ready, underrun;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int checkCount = 0;
  int errorCount = 0;
  int latency = 1;

  logic [7:0]  romArr [logic [23:0]];
  logic [7:0]  memArr [logic [23:0]];
  logic [23:0] wrAddrQ [$];
  logic [7:0]  wrDataQ [$];
  logic [23:0] rdAddrQ [$];
  logic        monitorOn = 1'b0;
  logic        sawValid, sawOe;

  qspi_psram_target dut (
    .clk_i(clk), .reset_i(reset), .ce_n_i(ce_n), .sclk_i(sclk), .sio_i(sio_i),
    .sio_o(sio_o), .sio_oe_o(sio_oe), .mem_valid_o(mem_valid), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready), .underrun_o(underrun)
  );

  always #5 clk = ~clk;

  // Memory model: acknowledges after 'latency' clocks and logs every completed access.
  initial begin
    int waitCnt;
    waitCnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_valid === 1'b1 && !reset) begin
        waitCnt++;
        if (waitCnt >= latency) begin
          waitCnt = 0;
          mem_ready = 1'b1;
          if (mem_we) begin
            memArr[mem_addr] = mem_wdata;
            wrAddrQ.push_back(mem_addr);
            wrDataQ.push_back(mem_wdata);
          end else begin
            rdAddrQ.push_back(mem_addr);
            if (memArr.exists(mem_addr)) mem_rdata = memArr[mem_addr];
            else if (romArr.exists(mem_addr)) mem_rdata = romArr[mem_addr];
            else mem_rdata = 8'h00;
          end
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Watches for any bus request or pad drive while enabled.
  always @(negedge clk) begin
    if (!monitorOn) begin
      sawValid = 1'b0;
      sawOe = 1'b0;
    end else begin
      if (mem_valid !== 1'b0) sawValid = 1'b1;
      if (sio_oe !== 4'h0) sawOe = 1'b1;
    end
  end

  task automatic halfSclk();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] nib);
    sio_i = nib;
    halfSclk();
    sclk = 1'b1;
    halfSclk();
    sclk = 1'b0;
  endtask

  task automatic readCycle(output logic [3:0] nib, output logic [3:0] oe);
    sio_i = 4'h0;
    halfSclk();
    nib = sio_o;
    oe = sio_oe;
    sclk = 1'b1;
    halfSclk();
    sclk = 1'b0;
  endtask

  task automatic sendCmd(input logic [7:0] cmd);
    ce_n = 1'b0;
    halfSclk();
    for (int i = 7; i >= 0; i--) applyStimulus({3'b000, cmd[i]});
  endtask

  task automatic startTxn(input logic [7:0] cmd, input logic [23:0] addr);
    sendCmd(cmd);
    for (int i = 5; i >= 0; i--) applyStimulus(addr[i*4 +: 4]);
  endtask

  task automatic dummyPhase(output logic [3:0] oeBeforeLast);
    for (int i = 0; i < 5; i++) applyStimulus(4'h0);
    sio_i = 4'h0;
    halfSclk();
    oeBeforeLast = sio_oe;
    sclk = 1'b1;
    halfSclk();
    sclk = 1'b0;
  endtask

  task automatic endTxn();
    ce_n = 1'b1;
    sclk = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkCount++; if (sio_o !== 4'h0) begin errorCount++; $display("[TB] FAIL reset_sio_o: got %h expected 0", sio_o); end
    checkCount++; if (sio_oe !== 4'h0) begin errorCount++; $display("[TB] FAIL reset_sio_oe: got %h expected 0", sio_oe); end
    checkCount++; if (mem_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_mem_valid: got %b expected 0", mem_valid); end
    checkCount++; if (mem_we !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
    checkCount++; if (mem_addr !== 24'h0) begin errorCount++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checkCount++; if (mem_wdata !== 8'h0) begin errorCount++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    checkCount++; if (underrun !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_write();
    int base;
    base = wrAddrQ.size();
    startTxn(8'h38, 24'h000010);
    applyStimulus(4'hA); applyStimulus(4'h5);
    applyStimulus(4'h3); applyStimulus(4'hC);
    endTxn();
    repeat (12) @(negedge clk);
    checkCount++;
    if (wrAddrQ.size() !== base + 2) begin errorCount++; $display("[TB] FAIL write_count: got %0d expected %0d", wrAddrQ.size() - base, 2); end
    if (wrAddrQ.size() >= base + 2) begin
      checkCount++; if (wrAddrQ[base] !== 24'h000010) begin errorCount++; $display("[TB] FAIL write0_addr: got %h expected 000010", wrAddrQ[base]); end
      checkCount++; if (wrDataQ[base] !== 8'hA5) begin errorCount++; $display("[TB] FAIL write0_data: got %h expected a5", wrDataQ[base]); end
      checkCount++; if (wrAddrQ[base+1] !== 24'h000011) begin errorCount++; $display("[TB] FAIL write1_addr: got %h expected 000011", wrAddrQ[base+1]); end
      checkCount++; if (wrDataQ[base+1] !== 8'h3C) begin errorCount++; $display("[TB] FAIL write1_data: got %h expected 3c", wrDataQ[base+1]); end
    end
    checkCount++; if (underrun !== 1'b0) begin errorCount++; $display("[TB] FAIL write_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_read();
    logic [3:0] nib, oe;
    logic [3:0] expNib [4];
    expNib = '{4'h1, 4'h2, 4'h3, 4'h4};
    romArr[24'h000020] = 8'h12;
    romArr[24'h000021] = 8'h34;
    startTxn(8'hEB, 24'h000020);
    dummyPhase(oe);
    checkCount++; if (oe !== 4'h0) begin errorCount++; $display("[TB] FAIL read_dummy_oe: got %h expected 0", oe); end
    for (int i = 0; i < 4; i++) begin
      readCycle(nib, oe);
      checkCount++; if (nib !== expNib[i]) begin errorCount++; $display("[TB] FAIL read_nibble%0d: got %h expected %h", i, nib, expNib[i]); end
      checkCount++; if (oe !== 4'hF) begin errorCount++; $display("[TB] FAIL read_oe%0d: got %h expected f", i, oe); end
    end
    endTxn();
    repeat (3) @(negedge clk);
    checkCount++; if (sio_oe !== 4'h0) begin errorCount++; $display("[TB] FAIL read_release_oe: got %h expected 0", sio_oe); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [3:0] nib, oe;
    logic [3:0] expNib [4];
    int base;
    expNib = '{4'hA, 4'hB, 4'hC, 4'hD};
    romArr[24'hFFFFFF] = 8'hAB;
    romArr[24'h000000] = 8'hCD;
    base = rdAddrQ.size();
    startTxn(8'hEB, 24'hFFFFFF);
    dummyPhase(oe);
    for (int i = 0; i < 4; i++) begin
      readCycle(nib, oe);
      checkCount++; if (nib !== expNib[i]) begin errorCount++; $display("[TB] FAIL wrap_nibble%0d: got %h expected %h", i, nib, expNib[i]); end
    end
    endTxn();
    repeat (12) @(negedge clk);
    checkCount++;
    if (rdAddrQ.size() < base + 2) begin errorCount++; $display("[TB] FAIL wrap_count: got %0d expected at least 2", rdAddrQ.size() - base); end
    else begin
      checkCount++; if (rdAddrQ[base] !== 24'hFFFFFF) begin errorCount++; $display("[TB] FAIL wrap_addr0: got %h expected ffffff", rdAddrQ[base]); end
      checkCount++; if (rdAddrQ[base+1] !== 24'h000000) begin errorCount++; $display("[TB] FAIL wrap_addr1: got %h expected 000000", rdAddrQ[base+1]); end
    end
  endtask

  task automatic test_unsupported();
    logic [3:0] nib, oe;
    logic gotValid, gotOe;
    monitorOn = 1'b1;
    sendCmd(8'h9F);
    for (int i = 0; i < 10; i++) applyStimulus(4'hF);
    endTxn();
    repeat (6) @(negedge clk);
    gotValid = sawValid;
    gotOe = sawOe;
    monitorOn = 1'b0;
    checkCount++; if (gotValid !== 1'b0) begin errorCount++; $display("[TB] FAIL unsupported_mem_valid: got %b expected 0", gotValid); end
    checkCount++; if (gotOe !== 1'b0) begin errorCount++; $display("[TB] FAIL unsupported_oe: got %b expected 0", gotOe); end
    startTxn(8'hEB, 24'h000020);
    dummyPhase(oe);
    readCycle(nib, oe);
    checkCount++; if (nib !== 4'h1) begin errorCount++; $display("[TB] FAIL after_unsupported_nib0: got %h expected 1", nib); end
    readCycle(nib, oe);
    checkCount++; if (nib !== 4'h2) begin errorCount++; $display("[TB] FAIL after_unsupported_nib1: got %h expected 2", nib); end
    endTxn();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_abort();
    int base;
    base = wrAddrQ.size();
    startTxn(8'h38, 24'h000040);
    applyStimulus(4'h9);
    endTxn();
    repeat (3) @(negedge clk);
    checkCount++; if (sio_oe !== 4'h0) begin errorCount++; $display("[TB] FAIL abort_oe: got %h expected 0", sio_oe); end
    repeat (20) @(negedge clk);
    checkCount++; if (wrAddrQ.size() !== base) begin errorCount++; $display("[TB] FAIL abort_no_write: got %0d writes expected 0", wrAddrQ.size() - base); end
    startTxn(8'h38, 24'h000040);
    applyStimulus(4'h7); applyStimulus(4'hE);
    endTxn();
    repeat (12) @(negedge clk);
    checkCount++;
    if (wrAddrQ.size() !== base + 1) begin errorCount++; $display("[TB] FAIL abort_next_count: got %0d expected 1", wrAddrQ.size() - base); end
    else begin
      checkCount++; if (wrAddrQ[base] !== 24'h000040) begin errorCount++; $display("[TB] FAIL abort_next_addr: got %h expected 000040", wrAddrQ[base]); end
      checkCount++; if (wrDataQ[base] !== 8'h7E) begin errorCount++; $display("[TB] FAIL abort_next_data: got %h expected 7e", wrDataQ[base]); end
    end
  endtask

  task automatic test_slow_backend();
    logic [3:0] nib, oe, firstNib;
    checkCount++; if (underrun !== 1'b0) begin errorCount++; $display("[TB] FAIL slow_underrun_before: got %b expected 0", underrun); end
    latency = 20;
    startTxn(8'hEB, 24'h000020);
    dummyPhase(oe);
    readCycle(firstNib, oe);
    for (int i = 0; i < 3; i++) readCycle(nib, oe);
    checkCount++; if (firstNib !== 4'h1) begin errorCount++; $display("[TB] FAIL slow_first_nib: got %h expected 1", firstNib); end
    checkCount++; if (underrun !== 1'b1) begin errorCount++; $display("[TB] FAIL slow_underrun: got %b expected 1", underrun); end
    endTxn();
    repeat (40) @(negedge clk);
    latency = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] nib, oe;
    startTxn(8'hEB, 24'h000020);
    dummyPhase(oe);
    readCycle(nib, oe);
    readCycle(nib, oe);
    checkCount++; if (sio_oe !== 4'hF) begin errorCount++; $display("[TB] FAIL midreset_pre_oe: got %h expected f", sio_oe); end
    reset = 1'b1;
    ce_n = 1'b1;
    @(negedge clk);
    checkCount++; if (sio_o !== 4'h0) begin errorCount++; $display("[TB] FAIL midreset_sio_o: got %h expected 0", sio_o); end
    checkCount++; if (sio_oe !== 4'h0) begin errorCount++; $display("[TB] FAIL midreset_sio_oe: got %h expected 0", sio_oe); end
    checkCount++; if (mem_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_mem_valid: got %b expected 0", mem_valid); end
    checkCount++; if (mem_we !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_mem_we: got %b expected 0", mem_we); end
    checkCount++; if (mem_addr !== 24'h0) begin errorCount++; $display("[TB] FAIL midreset_mem_addr: got %h expected 0", mem_addr); end
    checkCount++; if (mem_wdata !== 8'h0) begin errorCount++; $display("[TB] FAIL midreset_mem_wdata: got %h expected 0", mem_wdata); end
    checkCount++; if (underrun !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_underrun: got %b expected 0", underrun); end
    reset = 1'b0;
    endTxn();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting qspi_psram_target directed tests");
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_unsupported();
    test_abort();
    test_slow_backend();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
